// File: rtl/ov5640_init_seq.sv
// OV5640 power-up init sequencer: walks the register ROM and issues one SCCB write per entry.
// Optional NACK retry support is compiled in with `define OV5640_INIT_RETRY_EN.
module ov5640_init_seq #(
    parameter int         ROM_DEPTH   = 252,
    parameter int         ADDR_WIDTH  = 8,
    parameter logic [7:0] DEV_ADDR    = 8'h78,
    parameter int         POWERUP_CYC = 1_000_000,
    parameter int         RESET_CYC   = 250_000,
    parameter int         MAX_RETRY   = 3
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  start,
    output logic [ADDR_WIDTH-1:0] rom_addr,
    input  logic [23:0]           rom_q,
    output logic                  wr_req,
    output logic [7:0]            wr_dev_addr,
    output logic [15:0]           wr_reg_addr,
    output logic [7:0]            wr_data,
    input  logic                  wr_done,
    input  logic                  wr_nack,
    output logic                  busy,
    output logic                  init_done,
    output logic                  init_error
);

    localparam int CNT_MAX = (POWERUP_CYC > RESET_CYC) ? POWERUP_CYC : RESET_CYC;
    localparam int CNT_W   = (CNT_MAX < 2) ? 1 : $clog2(CNT_MAX + 1);

    localparam logic [CNT_W-1:0]      PWR_LAST = CNT_W'(POWERUP_CYC - 1);
    localparam logic [CNT_W-1:0]      RST_LAST = CNT_W'(RESET_CYC);
    localparam logic [CNT_W-1:0]      CNT_ONE  = CNT_W'(1);
    localparam logic [ADDR_WIDTH-1:0] LAST_IDX = ADDR_WIDTH'(ROM_DEPTH - 1);

    if (ROM_DEPTH < 1 || ROM_DEPTH > (1 << ADDR_WIDTH)) begin : g_bad_depth
        $error("ov5640_init_seq: ROM_DEPTH does not fit ADDR_WIDTH");
    end
    if (POWERUP_CYC < 1 || RESET_CYC < 1 || MAX_RETRY < 0) begin : g_bad_timing
        $error("ov5640_init_seq: POWERUP_CYC/RESET_CYC must be >= 1, MAX_RETRY >= 0");
    end

    typedef enum logic [2:0] {
        S_IDLE,
        S_PWR_WAIT,
        S_FETCH,
        S_ISSUE,
        S_WAIT_DONE,
        S_POST_DLY,
        S_DONE,
        S_ERROR
    } state_t;

    state_t                  state;
    state_t                  state_nxt;
    logic [ADDR_WIDTH-1:0]   idx;
    logic [ADDR_WIDTH-1:0]   idx_nxt;
    logic [CNT_W-1:0]        cnt;
    logic [CNT_W-1:0]        cnt_nxt;
    logic                    wr_req_nxt;
    logic                    busy_nxt;
    logic                    done_nxt;
    logic                    err_nxt;
    logic                    latch_en;
    logic                    is_reset_entry;

`ifdef OV5640_INIT_RETRY_EN
    localparam int RETRY_W = (MAX_RETRY < 1) ? 1 : $clog2(MAX_RETRY + 1);
    localparam logic [RETRY_W-1:0] RETRY_LAST = RETRY_W'(MAX_RETRY);

    logic [RETRY_W-1:0] retry_cnt;
    logic [RETRY_W-1:0] retry_nxt;
`endif

    // Sensor software reset: SYSTEM_CTRL0 (0x3008) with bit 7 set needs a settle delay.
    assign is_reset_entry = (wr_reg_addr == 16'h3008) && wr_data[7];

    assign rom_addr    = idx;
    assign wr_dev_addr = DEV_ADDR;

    always_comb begin
        state_nxt  = state;
        idx_nxt    = idx;
        cnt_nxt    = cnt;
        wr_req_nxt = 1'b0;
        done_nxt   = init_done;
        err_nxt    = init_error;
        latch_en   = 1'b0;
`ifdef OV5640_INIT_RETRY_EN
        retry_nxt  = retry_cnt;
`endif

        unique case (state)
            S_IDLE, S_DONE, S_ERROR: begin
                if (start) begin
                    state_nxt = S_PWR_WAIT;
                    idx_nxt   = '0;
                    cnt_nxt   = '0;
                    done_nxt  = 1'b0;
                    err_nxt   = 1'b0;
`ifdef OV5640_INIT_RETRY_EN
                    retry_nxt = '0;
`endif
                end
            end

            S_PWR_WAIT: begin
                if (cnt == PWR_LAST) begin
                    state_nxt = S_FETCH;
                    cnt_nxt   = '0;
                end else begin
                    cnt_nxt = cnt + CNT_ONE;
                end
            end

            // Cycle 0 presents the address, cycle 1 sees the registered ROM word.
            S_FETCH: begin
                if (cnt == CNT_ONE) begin
                    latch_en   = 1'b1;
                    wr_req_nxt = 1'b1;
                    state_nxt  = S_ISSUE;
                    cnt_nxt    = '0;
                end else begin
                    cnt_nxt = cnt + CNT_ONE;
                end
            end

            S_ISSUE: begin
                state_nxt = S_WAIT_DONE;
                cnt_nxt   = '0;
            end

            S_WAIT_DONE: begin
                if (wr_done) begin
                    cnt_nxt = '0;
                    if (!wr_nack) begin
                        if (is_reset_entry) begin
                            state_nxt = S_POST_DLY;
                        end else if (idx == LAST_IDX) begin
                            state_nxt = S_DONE;
                            done_nxt  = 1'b1;
                        end else begin
                            idx_nxt   = idx + 1'b1;
                            state_nxt = S_FETCH;
`ifdef OV5640_INIT_RETRY_EN
                            retry_nxt = '0;
`endif
                        end
                    end else begin
`ifdef OV5640_INIT_RETRY_EN
                        if (retry_cnt == RETRY_LAST) begin
                            state_nxt = S_ERROR;
                            err_nxt   = 1'b1;
                        end else begin
                            retry_nxt  = retry_cnt + 1'b1;
                            wr_req_nxt = 1'b1;
                            state_nxt  = S_ISSUE;
                        end
`else
                        state_nxt = S_ERROR;
                        err_nxt   = 1'b1;
`endif
                    end
                end
            end

            // Counts through RESET_CYC-1 and spends one more cycle before moving on.
            S_POST_DLY: begin
                if (cnt == RST_LAST) begin
                    cnt_nxt = '0;
                    if (idx == LAST_IDX) begin
                        state_nxt = S_DONE;
                        done_nxt  = 1'b1;
                    end else begin
                        idx_nxt   = idx + 1'b1;
                        state_nxt = S_FETCH;
`ifdef OV5640_INIT_RETRY_EN
                        retry_nxt = '0;
`endif
                    end
                end else begin
                    cnt_nxt = cnt + CNT_ONE;
                end
            end

            default: begin
                state_nxt = S_IDLE;
            end
        endcase

        busy_nxt = !((state_nxt == S_IDLE) || (state_nxt == S_DONE) || (state_nxt == S_ERROR));
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= S_IDLE;
            idx         <= '0;
            cnt         <= '0;
            wr_req      <= 1'b0;
            wr_reg_addr <= '0;
            wr_data     <= '0;
            busy        <= 1'b0;
            init_done   <= 1'b0;
            init_error  <= 1'b0;
        end else begin
            state      <= state_nxt;
            idx        <= idx_nxt;
            cnt        <= cnt_nxt;
            wr_req     <= wr_req_nxt;
            busy       <= busy_nxt;
            init_done  <= done_nxt;
            init_error <= err_nxt;
            if (latch_en) begin
                wr_reg_addr <= rom_q[23:8];
                wr_data     <= rom_q[7:0];
            end
        end
    end

`ifdef OV5640_INIT_RETRY_EN
    always_ff @(posedge clk) begin
        if (reset) begin
            retry_cnt <= '0;
        end else begin
            retry_cnt <= retry_nxt;
        end
    end
`endif

endmodule
